// File: rtl/adv7513_config_sequencer.sv
// adv7513_config_sequencer
// Brings up the HDMI transmitter by writing a fixed register table over a
// byte-level I2C master, retrying NACKed writes, then watches hot-plug detect
// (reg 0x42 bit 6) and rewrites the whole table after the sink is re-plugged.

module adv7513_config_sequencer #(
    parameter logic [6:0]  DEV_ADDR    = 7'h39,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned POLL_CYCLES = 40000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rw,
    output logic [6:0] cmd_dev,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       config_done,
    output logic       error,
    output logic [3:0] entry_idx
);

    localparam int unsigned N_ENTRIES = 11;
    localparam logic [3:0]  LAST_IDX  = 4'(N_ENTRIES - 1);
    localparam int          TIMER_W   = (POLL_CYCLES < 2) ? 1 : $clog2(POLL_CYCLES);
    localparam int          RETRY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [TIMER_W-1:0] POLL_LAST = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [7:0]  HPD_REG   = 8'h42;
    localparam int          HPD_BIT   = 6;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        DONE,
        POLL_ISSUE,
        POLL_WAIT,
        WAIT_HPD,
        ERROR
    } state_t;

    // Register table: {sub-address, data} per entry, written in index order.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = 16'h41_10;
            4'd1:    table_entry = 16'h98_03;
            4'd2:    table_entry = 16'h9A_E0;
            4'd3:    table_entry = 16'h9C_30;
            4'd4:    table_entry = 16'h9D_61;
            4'd5:    table_entry = 16'hA2_A4;
            4'd6:    table_entry = 16'hA3_A4;
            4'd7:    table_entry = 16'hE0_D0;
            4'd8:    table_entry = 16'hF9_00;
            4'd9:    table_entry = 16'h15_00;
            4'd10:   table_entry = 16'h16_30;
            default: table_entry = 16'h00_00;
        endcase
    endfunction

    state_t               state;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [TIMER_W-1:0]   poll_timer;
    logic                 poll_from_done;

    logic [3:0]  next_idx;
    logic [15:0] tbl_next;
    logic [15:0] tbl_first;
    logic        unused_rdata;

    assign next_idx     = entry_idx + 4'd1;
    assign tbl_next     = table_entry(next_idx);
    assign tbl_first    = table_entry(4'd0);
    assign unused_rdata = ^{rsp_rdata[7], rsp_rdata[5:0]};

    // Sequencer FSM: all outputs are registered and change only on state transitions.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            retry_cnt      <= '0;
            poll_timer     <= '0;
            poll_from_done <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_rw         <= 1'b0;
            cmd_dev        <= '0;
            cmd_reg        <= '0;
            cmd_wdata      <= '0;
            busy           <= 1'b0;
            config_done    <= 1'b0;
            error          <= 1'b0;
            entry_idx      <= '0;
        end else begin
            case (state)
                IDLE, ERROR: begin
                    if (start) begin
                        state       <= ISSUE;
                        entry_idx   <= '0;
                        retry_cnt   <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        config_done <= 1'b0;
                        cmd_valid   <= 1'b1;
                        cmd_rw      <= 1'b0;
                        cmd_dev     <= DEV_ADDR;
                        cmd_reg     <= tbl_first[15:8];
                        cmd_wdata   <= tbl_first[7:0];
                    end
                end

                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (!rsp_nack) begin
                            retry_cnt <= '0;
                            entry_idx <= next_idx;
                            if (entry_idx == LAST_IDX) begin
                                state       <= DONE;
                                busy        <= 1'b0;
                                config_done <= 1'b1;
                                poll_timer  <= '0;
                            end else begin
                                state     <= ISSUE;
                                cmd_valid <= 1'b1;
                                cmd_reg   <= tbl_next[15:8];
                                cmd_wdata <= tbl_next[7:0];
                            end
                        end else if (retry_cnt < RETRY_MAX) begin
                            // Same entry again: command fields are still loaded.
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ISSUE;
                            cmd_valid <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end

                DONE, WAIT_HPD: begin
                    if (poll_timer == POLL_LAST) begin
                        poll_timer     <= '0;
                        poll_from_done <= (state == DONE);
                        state          <= POLL_ISSUE;
                        cmd_valid      <= 1'b1;
                        cmd_rw         <= 1'b1;
                        cmd_dev        <= DEV_ADDR;
                        cmd_reg        <= HPD_REG;
                        cmd_wdata      <= 8'h00;
                    end else begin
                        poll_timer <= poll_timer + 1'b1;
                    end
                end

                POLL_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= POLL_WAIT;
                    end
                end

                POLL_WAIT: begin
                    if (rsp_valid) begin
                        if (rsp_nack) begin
                            // A failed poll is not an error; just try again next period.
                            state <= poll_from_done ? DONE : WAIT_HPD;
                        end else if (!rsp_rdata[HPD_BIT]) begin
                            state       <= WAIT_HPD;
                            config_done <= 1'b0;
                        end else if (poll_from_done) begin
                            state <= DONE;
                        end else begin
                            // Re-plug: the transmitter lost its settings, rewrite everything.
                            state     <= ISSUE;
                            entry_idx <= '0;
                            retry_cnt <= '0;
                            busy      <= 1'b1;
                            cmd_valid <= 1'b1;
                            cmd_rw    <= 1'b0;
                            cmd_dev   <= DEV_ADDR;
                            cmd_reg   <= tbl_first[15:8];
                            cmd_wdata <= tbl_first[7:0];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adv7513_config_sequencer.sv
// tb_adv7513_config_sequencer
// I2C master model with configurable NACK injection and HPD read data; a
// scoreboard queue holds the expected write commands and is drained as the
// sequencer's commands are accepted.

module tb_adv7513_config_sequencer;

    localparam logic [6:0] DEV  = 7'h39;
    localparam int         MAXR = 3;
    localparam int         POLL = 8;

    localparam logic [15:0] REF_TABLE [11] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
        16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630
    };

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       rsp_valid = 1'b0;
    logic       rsp_nack = 1'b0;
    logic [7:0] rsp_rdata = 8'h00;
    logic       cmd_valid;
    logic       cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       busy;
    logic       config_done;
    logic       error;
    logic [3:0] entry_idx;

    int n_checks = 0;
    int n_fail = 0;

    logic [22:0] exp_q[$];
    int          writes_seen = 0;
    int          reads_seen = 0;
    int          rsp_cnt = 0;
    bit          pend_nack = 1'b0;
    bit          pend_read = 1'b0;
    logic [7:0]  hpd_data = 8'h40;
    logic [7:0]  nack_reg = 8'h00;
    int          nack_left = 0;

    adv7513_config_sequencer #(
        .DEV_ADDR    (DEV),
        .MAX_RETRIES (MAXR),
        .POLL_CYCLES (POLL)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_dev     (cmd_dev),
        .cmd_reg     (cmd_reg),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_nack    (rsp_nack),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy),
        .config_done (config_done),
        .error       (error),
        .entry_idx   (entry_idx)
    );

    always #5 clock = ~clock;

    // I2C master model and scoreboard: looks at the handshake half a cycle before the
    // accepting edge, answers two cycles after acceptance.
    initial begin : responder
        logic [22:0] exp;
        forever begin
            @(negedge clock);
            #1;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            rsp_rdata = 8'h00;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_nack  = pend_nack;
                    rsp_rdata = pend_read ? hpd_data : 8'h00;
                end
            end
            if (reset_n && cmd_valid && cmd_ready) begin
                n_checks++;
                if (rsp_cnt != 0 || rsp_valid) begin
                    n_fail++;
                    $display("FAIL overlap: command accepted with response outstanding (reg %h)", cmd_reg);
                end
                if (!cmd_rw) begin
                    writes_seen++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got dev %h reg %h data %h, expected none",
                                 cmd_dev, cmd_reg, cmd_wdata);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({cmd_dev, cmd_reg, cmd_wdata} !== exp) begin
                            n_fail++;
                            $display("FAIL write_cmd: got %h/%h/%h, expected %h/%h/%h",
                                     cmd_dev, cmd_reg, cmd_wdata, exp[22:16], exp[15:8], exp[7:0]);
                        end
                    end
                    pend_read = 1'b0;
                    pend_nack = (cmd_reg == nack_reg) && (nack_left > 0);
                    if (pend_nack) nack_left--;
                end else begin
                    reads_seen++;
                    n_checks++;
                    if ({cmd_dev, cmd_reg, cmd_wdata} !== {DEV, 8'h42, 8'h00}) begin
                        n_fail++;
                        $display("FAIL poll_cmd: got %h/%h/%h, expected %h/42/00",
                                 cmd_dev, cmd_reg, cmd_wdata, DEV);
                    end
                    pend_read = 1'b1;
                    pend_nack = 1'b0;
                end
                rsp_cnt = 2;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        start     = 1'b0;
        cmd_ready = 1'b1;
        reset_n   = 1'b0;
        exp_q.delete();
        nack_left = 0;
        hpd_data  = 8'h40;
        repeat (4) @(negedge clock);
        writes_seen = 0;
        reads_seen  = 0;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic push_entry(input int i);
        exp_q.push_back({DEV, REF_TABLE[i]});
    endtask

    task automatic push_table();
        for (int i = 0; i < 11; i++) push_entry(i);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (config_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cmd_ready = 1'b1;
        reset_n = 1'b0;
        #3;
        n_checks++;
        if ({cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_cmd: got %h, expected 0", {cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata});
        end
        n_checks++;
        if ({busy, config_done, error, entry_idx} !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %b, expected 0", {busy, config_done, error, entry_idx});
        end
        do_reset();
        repeat (5) @(negedge clock);
        n_checks++;
        if ({cmd_valid, busy, config_done, error} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b, expected 0000", {cmd_valid, busy, config_done, error});
        end
    endtask

    task automatic test_all_ack();
        bit ok;
        do_reset();
        push_table();
        pulse_start();
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL all_ack_done: config_done never rose, expected 1");
        end
        n_checks++;
        if ({error, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL all_ack_flags: error/busy %b, expected 00", {error, busy});
        end
        n_checks++;
        if (exp_q.size() != 0 || writes_seen != 11) begin
            n_fail++;
            $display("FAIL all_ack_count: writes %0d left %0d, expected 11 and 0", writes_seen, exp_q.size());
        end
        repeat (30) @(negedge clock);
        n_checks++;
        if (!config_done || reads_seen == 0) begin
            n_fail++;
            $display("FAIL hpd_poll_stay: done %b reads %0d, expected 1 and >0", config_done, reads_seen);
        end
    endtask

    task automatic test_retry();
        bit ok;
        do_reset();
        nack_reg  = 8'h9C;
        nack_left = 2;
        for (int i = 0; i < 3; i++) push_entry(i);
        repeat (3) push_entry(3);
        for (int i = 4; i < 11; i++) push_entry(i);
        pulse_start();
        wait_done(300, ok);
        n_checks++;
        if (!ok || error !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_done: done %b error %b, expected 1 0", ok, error);
        end
        n_checks++;
        if (exp_q.size() != 0 || writes_seen != 13) begin
            n_fail++;
            $display("FAIL retry_count: writes %0d left %0d, expected 13 and 0", writes_seen, exp_q.size());
        end
    endtask

    task automatic test_error();
        bit ok;
        do_reset();
        nack_reg  = 8'h41;
        nack_left = 1000;
        repeat (4) push_entry(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (error) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clock);
        n_checks++;
        if (!ok || {error, busy, config_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL error_state: error/busy/done %b, expected 100", {error, busy, config_done});
        end
        n_checks++;
        if (writes_seen != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL error_attempts: attempts %0d, expected 4", writes_seen);
        end
        nack_left = 0;
        push_table();
        pulse_start();
        n_checks++;
        if ({error, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL error_clear: error/busy %b, expected 01", {error, busy});
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL error_rerun: done %b left %0d, expected 1 and 0", ok, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [24:0] held;
        do_reset();
        cmd_ready = 1'b0;
        push_table();
        pulse_start();
        held = {cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata};
        n_checks++;
        if (held !== {1'b1, 1'b0, DEV, 8'h41, 8'h10}) begin
            n_fail++;
            $display("FAIL bp_first_cmd: got %h, expected %h", held, {1'b1, 1'b0, DEV, 8'h41, 8'h10});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_checks++;
            if ({cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata} !== held) begin
                n_fail++;
                $display("FAIL bp_stable: cycle %0d got %h, expected %h", i,
                         {cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata}, held);
            end
        end
        n_checks++;
        if (writes_seen != 0) begin
            n_fail++;
            $display("FAIL bp_no_accept: accepted %0d, expected 0", writes_seen);
        end
        cmd_ready = 1'b1;
        wait_done(200, ok);
        n_checks++;
        if (!ok || writes_seen != 11 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_complete: done %b writes %0d, expected 1 and 11", ok, writes_seen);
        end
    endtask

    task automatic test_hotplug();
        bit ok;
        do_reset();
        push_table();
        pulse_start();
        wait_done(200, ok);
        hpd_data = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!config_done) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL unplug: done dropped %b busy %b, expected 1 0", ok, busy);
        end
        push_table();
        hpd_data = 8'h40;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL replug_rewrite: busy never rose, expected 1");
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok || writes_seen != 22 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL replug_done: done %b writes %0d, expected 1 and 22", ok, writes_seen);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        do_reset();
        for (int i = 0; i < 6; i++) push_entry(i);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #2;
            if (writes_seen >= 6) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
        #2;
        n_checks++;
        if (!ok || busy !== 1'b1 || entry_idx !== 4'd5) begin
            n_fail++;
            $display("FAIL midflight_state: busy %b idx %0d, expected 1 5", busy, entry_idx);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_valid, busy, config_done, error, entry_idx} !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected 0", {cmd_valid, busy, config_done, error, entry_idx});
        end
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if ({cmd_valid, busy, entry_idx} !== 6'h0) begin
                n_fail++;
                $display("FAIL stray_rsp: cycle %0d got %b, expected 0", i, {cmd_valid, busy, entry_idx});
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midflight_count: left %0d, expected 0", exp_q.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_all_ack();
        test_retry();
        test_error();
        test_backpressure();
        test_hotplug();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
